// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the batch engine.
//   AES_ROUNDS  : number of AES-128 rounds
//   BLOCK_W     : block and key width in bits
//   state_t     : control FSM states of the batch engine
//   sbox()      : forward S-box lookup
//   xtime()     : multiply by x in GF(2^8)
//   rcon()      : key-schedule round constant for rounds 1..10
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int BLOCK_W    = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Entry x sits at bits [2047-8x -: 8], so the table reads in natural order.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX_TABLE[2047 - 8*idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round_idx);
    case (round_idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One full AES-128 encryption round with on-the-fly key expansion.
// Purely combinational; the caller registers state and key between rounds.
//   state_in   : state after the previous round
//   key_in     : round key used by the previous round
//   round_idx  : index of the round being computed (1..10), selects rcon
//   last_round : skip MixColumns (final round)
//   state_out  : state after this round
//   key_out    : round key for this round (fed back for the next one)
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [3:0]         round_idx,
  input  logic               last_round,
  output logic [BLOCK_W-1:0] state_out,
  output logic [BLOCK_W-1:0] key_out
);

  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] temp;
  logic [31:0] k0, k1, k2, k3;

  // Key schedule: w3 is rotated, substituted and salted with rcon.
  always_comb begin
    temp = {sbox(key_in[23:16]), sbox(key_in[15:8]), sbox(key_in[7:0]),
            sbox(key_in[31:24])} ^ {rcon(round_idx), 24'h0};
    k0 = key_in[127:96] ^ temp;
    k1 = key_in[95:64]  ^ k0;
    k2 = key_in[63:32]  ^ k1;
    k3 = key_in[31:0]   ^ k2;
    key_out = {k0, k1, k2, k3};
  end

  // Byte i of the block is row i%4, column i/4. SubBytes and ShiftRows
  // merge into one lookup: row r of column c comes from column (c+r)%4.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r + 4*c] = sbox(state_in[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    // NOTE: a default before the loop keeps every bit assigned on every
    // path; without it the variable part-selects can infer a latch.
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[127 - 8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ key_out[127 - 8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_batch_engine.sv
// Batch AES-128 engine: N lanes encrypt in lock-step, one round per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : batch input handshake
//   in_mask             : per-lane enable of the offered batch
//   in_data, in_key     : per-lane block and key, lane j at [128j+127:128j]
//   iv                  : CTR nonce (upper 128-CTR_W bits used)
//   ctr_load, ctr_init  : CTR counter load
//   out_valid/out_ready : result handshake
//   out_mask, out_data  : accepted mask and per-lane result
//   busy                : FSM is not idle
//   round_cnt           : last completed round (0..10)
//   batch_cnt           : delivered batches, wraps at 2^16
// MODE 0 = ECB, MODE 1 = CTR (counter logic generated only in CTR).
module aes_batch_engine
  import aes_pkg::*;
#(
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CTR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_mask,
  input  logic [BLOCK_W*N-1:0] in_data,
  input  logic [BLOCK_W*N-1:0] in_key,
  input  logic [BLOCK_W-1:0]   iv,
  input  logic                 ctr_load,
  input  logic [CTR_W-1:0]     ctr_init,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_mask,
  output logic [BLOCK_W*N-1:0] out_data,
  output logic                 busy,
  output logic [3:0]           round_cnt,
  output logic [15:0]          batch_cnt
);

  state_t               state_q, state_d;
  logic                 in_fire, out_fire, finishing, last_round, load_blocked;
  logic [3:0]           round_idx;
  logic [N-1:0]         mask_q;
  logic [BLOCK_W*N-1:0] st_q, key_q, st_nx, key_nx;
  logic [BLOCK_W*N-1:0] block_in, xor_src, result;

  // ---------------- mode-specific block source ----------------
  if (MODE == 1) begin : g_ctr
    logic [CTR_W-1:0]     ctr_q;
    logic [BLOCK_W*N-1:0] data_q;
    logic                 iv_low_unused;

    assign iv_low_unused = ^iv[CTR_W-1:0];
    assign load_blocked  = ctr_load;
    assign xor_src       = data_q;

    // A load takes priority; it also blocks in_ready, so both never coincide.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           ctr_q <= '0;
      else if (ctr_load) ctr_q <= ctr_init;
      else if (in_fire)  ctr_q <= ctr_q + CTR_W'(N);
    end

    always_ff @(posedge clk) begin
      if (in_fire) data_q <= in_data;
    end

    // Masked-off lanes still get their counter value, so ctr advances by N.
    for (genvar j = 0; j < N; j++) begin : g_blk
      assign block_in[BLOCK_W*j +: BLOCK_W] = {iv[BLOCK_W-1:CTR_W], ctr_q + CTR_W'(j)};
    end
  end else begin : g_ecb
    logic ecb_unused;

    assign ecb_unused   = ^{iv, ctr_load, ctr_init};
    assign load_blocked = 1'b0;
    assign xor_src      = '0;
    assign block_in     = in_data;
  end

  // ---------------- handshakes and status ----------------
  assign in_ready   = ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready)) && !load_blocked;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign busy       = (state_q != ST_IDLE);
  assign last_round = (round_cnt == 4'(AES_ROUNDS - 1));
  assign finishing  = (state_q == ST_RUN) && last_round;
  assign round_idx  = round_cnt + 4'd1;

  // ---------------- lanes ----------------
  for (genvar j = 0; j < N; j++) begin : g_lane
    aes_round_unit u_round (
      .state_in  (st_q  [BLOCK_W*j +: BLOCK_W]),
      .key_in    (key_q [BLOCK_W*j +: BLOCK_W]),
      .round_idx (round_idx),
      .last_round(last_round),
      .state_out (st_nx [BLOCK_W*j +: BLOCK_W]),
      .key_out   (key_nx[BLOCK_W*j +: BLOCK_W])
    );

    assign result[BLOCK_W*j +: BLOCK_W] =
      mask_q[j] ? (st_nx[BLOCK_W*j +: BLOCK_W] ^ xor_src[BLOCK_W*j +: BLOCK_W]) : '0;
  end

  // NOTE: the round state and key pipeline carry no reset; nothing leaves
  // them except through out_data, which is only written at the end of a
  // fully loaded batch, so reset would cost flops without changing behaviour.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      st_q  <= block_in ^ in_key;
      key_q <= in_key;
    end else if (state_q == ST_RUN) begin
      st_q  <= st_nx;
      key_q <= key_nx;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_fire)   state_d = ST_RUN;
      ST_RUN:  if (last_round) state_d = ST_DONE;
      ST_DONE: if (out_fire)  state_d = in_fire ? ST_RUN : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt <= '0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      batch_cnt <= '0;
    end else begin
      if (in_fire) begin
        round_cnt <= '0;
        mask_q    <= in_mask;
      end else if (state_q == ST_RUN) begin
        round_cnt <= round_idx;
      end

      if (finishing) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_mask  <= mask_q;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (out_fire) batch_cnt <= batch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_batch_engine.sv
// Self-checking bench: an ECB instance and a CTR instance (N=4, CTR_W=32)
// share stimulus; 'sel' picks which one receives in_valid and is observed.
// Expected results come from a byte-level AES-128 model whose S-box is
// derived from GF(2^8) inversion plus the affine map.
module tb_aes_batch_engine;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, ctr_load = 1'b0;
  logic [3:0]   in_mask = '0;
  logic [511:0] in_data = '0, in_key = '0;
  logic [127:0] iv = '0;
  logic [31:0]  ctr_init = '0;

  logic         e_in_valid, e_in_ready, e_out_valid, e_busy;
  logic         c_in_valid, c_in_ready, c_out_valid, c_busy;
  logic [3:0]   e_out_mask, c_out_mask, e_round_cnt, c_round_cnt;
  logic [511:0] e_out_data, c_out_data;
  logic [15:0]  e_batch_cnt, c_batch_cnt;

  logic         m_in_ready, m_out_valid, m_busy;
  logic [3:0]   m_out_mask, m_round_cnt;
  logic [511:0] m_out_data;
  logic [15:0]  m_batch_cnt;

  always #5 clk = ~clk;

  assign e_in_valid  = in_valid & ~sel;
  assign c_in_valid  = in_valid & sel;
  assign m_in_ready  = sel ? c_in_ready  : e_in_ready;
  assign m_out_valid = sel ? c_out_valid : e_out_valid;
  assign m_busy      = sel ? c_busy      : e_busy;
  assign m_out_mask  = sel ? c_out_mask  : e_out_mask;
  assign m_round_cnt = sel ? c_round_cnt : e_round_cnt;
  assign m_out_data  = sel ? c_out_data  : e_out_data;
  assign m_batch_cnt = sel ? c_batch_cnt : e_batch_cnt;

  aes_batch_engine #(.N(N), .MODE(0), .CTR_W(32)) u_ecb (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_mask(in_mask), .in_data(in_data), .in_key(in_key), .iv(iv),
    .ctr_load(ctr_load), .ctr_init(ctr_init), .out_valid(e_out_valid),
    .out_ready(out_ready), .out_mask(e_out_mask), .out_data(e_out_data),
    .busy(e_busy), .round_cnt(e_round_cnt), .batch_cnt(e_batch_cnt)
  );

  aes_batch_engine #(.N(N), .MODE(1), .CTR_W(32)) u_ctr (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_mask(in_mask), .in_data(in_data), .in_key(in_key), .iv(iv),
    .ctr_load(ctr_load), .ctr_init(ctr_init), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_mask(c_out_mask), .out_data(c_out_data),
    .busy(c_busy), .round_cnt(c_round_cnt), .batch_cnt(c_batch_cnt)
  );

  int           vectors = 0;
  int           miscompares = 0;
  logic [7:0]   sbox_tab [256];
  logic [31:0]  model_ctr = '0;
  int           model_bcnt [2] = '{0, 0};
  logic [511:0] exp_data;
  logic [3:0]   exp_mask;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   ks [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [4];
    logic [7:0]   a [4];
    logic [7:0]   rc, x;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      ks[i] = key[127 - 8*i -: 8];
      s[i]  = pt[127 - 8*i -: 8] ^ ks[i];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int k = 0; k < 4; k++) w[k] = ks[i - 4 + k];
      if (i % 16 == 0) begin
        x = w[0];
        w[0] = sbox_tab[w[1]] ^ rc;
        w[1] = sbox_tab[w[2]];
        w[2] = sbox_tab[w[3]];
        w[3] = sbox_tab[x];
        rc = gmul(rc, 8'h02);
      end
      for (int k = 0; k < 4; k++) ks[i + k] = ks[i - 16 + k] ^ w[k];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = s[4*c + k];
          s[4*c]     = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[4*c + 1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[4*c + 2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[4*c + 3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[16*r + i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Expected batch for the selected instance, using the model counter.
  function automatic logic [511:0] model_batch(input logic [3:0] m, input logic [511:0] d,
                                               input logic [511:0] k);
    logic [511:0] r = '0;
    logic [31:0]  cv;
    for (int j = 0; j < N; j++) begin
      cv = model_ctr + 32'(j);
      if (m[j]) begin
        if (sel) r[128*j +: 128] = d[128*j +: 128] ^ ref_aes(k[128*j +: 128], {iv[127:32], cv});
        else     r[128*j +: 128] = ref_aes(k[128*j +: 128], d[128*j +: 128]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] rand512();
    return {rand128(), rand128(), rand128(), rand128()};
  endfunction

  // ---------------- transaction procedures (start/end just after negedge) ----------------
  task automatic send_batch(input logic [3:0] m, input logic [511:0] d, input logic [511:0] k,
                            input bit with_ready, output int waited);
    in_mask = m; in_data = d; in_key = k; in_valid = 1'b1; out_ready = with_ready;
    waited = 0;
    #1;
    while (!m_in_ready && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!m_in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", m_in_ready, waited);
      in_valid = 1'b0; out_ready = 1'b0;
      return;
    end
    exp_data = model_batch(m, d, k);
    exp_mask = m;
    if (with_ready && m_out_valid) model_bcnt[int'(sel)]++;
    if (sel) model_ctr = model_ctr + 32'(N);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic wait_result(input int start_k);
    int k = start_k;
    while (!m_out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k !== 10) begin miscompares++; $display("FAIL latency: got %0d cycles, want 10", k); end
    vectors++;
    if (m_out_data !== exp_data) begin
      miscompares++; $display("FAIL out_data: got %h want %h", m_out_data, exp_data);
    end
    vectors++;
    if (m_out_mask !== exp_mask) begin
      miscompares++; $display("FAIL out_mask: got %b want %b", m_out_mask, exp_mask);
    end
    vectors++;
    if (m_round_cnt !== 4'd10) begin
      miscompares++; $display("FAIL round_cnt_done: got %0d want 10", m_round_cnt);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_bcnt[int'(sel)]++;
    vectors++;
    if (m_out_valid !== 1'b0 || m_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL release: out_valid=%b busy=%b, want 0 0", m_out_valid, m_busy);
    end
    vectors++;
    if (m_batch_cnt !== 16'(model_bcnt[int'(sel)])) begin
      miscompares++;
      $display("FAIL batch_cnt: got %0d want %0d", m_batch_cnt, model_bcnt[int'(sel)]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({e_out_valid, e_busy, e_round_cnt, e_batch_cnt, e_out_mask} !== '0 || e_out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_ecb: valid=%b busy=%b rc=%0d bc=%0d mask=%b, want all 0",
               e_out_valid, e_busy, e_round_cnt, e_batch_cnt, e_out_mask);
    end
    vectors++;
    if ({c_out_valid, c_busy, c_round_cnt, c_batch_cnt, c_out_mask} !== '0 || c_out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_ctr: valid=%b busy=%b rc=%0d bc=%0d mask=%b, want all 0",
               c_out_valid, c_busy, c_round_cnt, c_batch_cnt, c_out_mask);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (e_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: ecb=%b ctr=%b, want 1 1", e_in_ready, c_in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_fips_ecb();
    int w;
    sel = 1'b0;
    send_batch(4'hf, {4{FIPS_PT}}, {4{FIPS_KEY}}, 1'b0, w);
    exp_data = {4{FIPS_CT}};
    wait_result(0);
    take_result();
  endtask

  task automatic test_mask_lane2();
    int w;
    sel = 1'b0;
    send_batch(4'b0100, {rand128(), 128'h3243f6a8885a308d313198a2e0370734, rand256()},
               {rand128(), 128'h2b7e151628aed2a6abf7158809cf4f3c, rand256()}, 1'b0, w);
    exp_data = {128'h0, 128'h3925841d02dc09fbdc118597196a0b32, 256'h0};
    wait_result(0);
    take_result();
  endtask

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  task automatic test_random_ecb();
    int w;
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_batch(4'($urandom_range(0, 15)), rand512(), rand512(), 1'b0, w);
      wait_result(0);
      take_result();
    end
  endtask

  task automatic test_ctr();
    int w;
    sel = 1'b1;
    iv = rand128();
    // Load and offer together: no accept this cycle, accept next cycle.
    ctr_load = 1'b1; ctr_init = 32'hfffffffe; in_valid = 1'b1; in_mask = 4'hf;
    #1;
    vectors++;
    if (c_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL load_blocks_accept: in_ready=%b want 0", c_in_ready);
    end
    @(negedge clk);
    ctr_load = 1'b0;
    model_ctr = 32'hfffffffe;
    send_batch(4'hf, rand512(), rand512(), 1'b0, w);
    vectors++;
    if (w !== 0) begin miscompares++; $display("FAIL accept_after_load: waited %0d want 0", w); end
    wait_result(0);
    take_result();
    // Counter wrapped to 2; masked lanes still consume values.
    send_batch(4'b1010, rand512(), rand512(), 1'b0, w);
    wait_result(0);
    take_result();
    // A load while a batch is in flight must not disturb that batch.
    send_batch(4'($urandom_range(1, 15)), rand512(), rand512(), 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    ctr_load = 1'b1; ctr_init = $urandom;
    @(negedge clk);
    ctr_load = 1'b0;
    model_ctr = ctr_init;
    wait_result(3);
    take_result();
    send_batch(4'hf, rand512(), rand512(), 1'b0, w);
    wait_result(0);
    take_result();
  endtask

  task automatic test_reset_midflight();
    int w;
    bit stayed_low = 1'b1;
    sel = 1'b0;
    send_batch(4'hf, {4{FIPS_PT}}, {4{FIPS_KEY}}, 1'b0, w);
    repeat (5) @(negedge clk);
    vectors++;
    if (m_round_cnt !== 4'd5) begin
      miscompares++; $display("FAIL round_cnt_mid: got %0d want 5", m_round_cnt);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (e_round_cnt !== 4'd0 || e_busy !== 1'b0 || e_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: rc=%0d busy=%b valid=%b, want 0 0 0", e_round_cnt, e_busy, e_out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ctr = '0;
    model_bcnt = '{0, 0};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (e_out_valid !== 1'b0 || e_round_cnt !== 4'd0) stayed_low = 1'b0;
    end
    vectors++;
    if (!stayed_low) begin
      miscompares++; $display("FAIL discard_after_reset: output appeared, want none");
    end
    // Counter restarted at zero.
    sel = 1'b1;
    iv = rand128();
    send_batch(4'hf, rand512(), rand512(), 1'b0, w);
    wait_result(0);
    take_result();
    sel = 1'b0;
    send_batch(4'hf, {4{FIPS_PT}}, {4{FIPS_KEY}}, 1'b0, w);
    exp_data = {4{FIPS_CT}};
    wait_result(0);
    take_result();
  endtask

  task automatic test_back_to_back();
    int w;
    bit held = 1'b1;
    logic [511:0] first;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ctr = '0;
    model_bcnt = '{0, 0};
    sel = 1'b0;
    send_batch(4'hf, rand512(), rand512(), 1'b0, w);
    wait_result(0);
    first = exp_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_out_valid !== 1'b1 || m_out_data !== first || m_in_ready !== 1'b0) held = 1'b0;
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL hold: valid=%b ready=%b data=%h want stable %h", m_out_valid, m_in_ready,
               m_out_data, first);
    end
    send_batch(4'($urandom_range(1, 15)), rand512(), rand512(), 1'b1, w);
    vectors++;
    if (m_batch_cnt !== 16'd1 || m_out_valid !== 1'b0 || m_round_cnt !== 4'd0 || m_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: bc=%0d valid=%b rc=%0d busy=%b, want 1 0 0 1", m_batch_cnt,
               m_out_valid, m_round_cnt, m_busy);
    end
    wait_result(0);
    take_result();
    vectors++;
    if (m_batch_cnt !== 16'd2) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 2", m_batch_cnt);
    end
  endtask

  task automatic test_ecb_ignores_ctr_load();
    int w;
    sel = 1'b0;
    ctr_load = 1'b1;
    in_valid = 1'b1;
    #1;
    vectors++;
    if (e_in_ready !== 1'b1 || c_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ecb_ctr_load: ecb_ready=%b ctr_ready=%b, want 1 0", e_in_ready, c_in_ready);
    end
    send_batch(4'hf, rand512(), rand512(), 1'b0, w);
    ctr_load = 1'b0;
    wait_result(0);
    take_result();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_ecb();
    test_mask_lane2();
    test_random_ecb();
    test_ctr();
    test_reset_midflight();
    test_back_to_back();
    test_ecb_ignores_ctr_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
